shift_seq: RTL

SHIFT_SEQ -- requirements
Module: shift_seq

---
 rtl/shift_pkg.sv | 17 +
 rtl/shift_step.sv | 20 ++
 rtl/shift_seq.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared encodings for the sequential shifter: operation codes and FSM states.
package shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves data left or right by 0..STEP bits,
// filling vacated right-shift positions with the fill bit.
module shift_step #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic [WIDTH-1:0]        data,
  input  logic                    dir_left,
  input  logic                    fill,
  input  logic [$clog2(STEP):0]   amt,
  output logic [WIDTH-1:0]        result
);

  logic [WIDTH-1:0] fill_mask;

  // Ones in the top amt positions, used only for sign fill on right shifts.
  assign fill_mask = fill ? ~({WIDTH{1'b1}} >> amt) : '0;
  assign result    = dir_left ? (data << amt) : ((data >> amt) | fill_mask);

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle barrel-free shifter: applies at most STEP bits per cycle with a
// valid/ready handshake. Define SHIFT_SEQ_SRA_EN to enable arithmetic right shift.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// SHIFT | working register shifting, rem counting down to zero
// DONE  | result presented on out, waiting for out_ready
module shift_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             busy
);

  localparam int SW = $clog2(WIDTH);
  localparam int AW = $clog2(STEP) + 1;
  localparam logic [SW-1:0] STEP_R = SW'(STEP);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [SW-1:0]    rem_q, rem_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic             accept;
  logic             is_sra;
  logic             dir_left;
  logic             fill;
  logic [AW-1:0]    step_amt;
  logic [SW-1:0]    rem_next;
  logic [WIDTH-1:0] step_res;
  logic [SW-1:0]    shamt;
  logic             unused_b_hi;

  assign shamt       = b[SW-1:0];
  assign unused_b_hi = ^b[WIDTH-1:SW];
  assign accept      = in_valid & in_ready_q;

`ifdef SHIFT_SEQ_SRA_EN
  assign is_sra = (op_q == OP_SRA);
`else
  assign is_sra = 1'b0;
`endif

  // The working MSB keeps the sign during SRA, so it serves as the fill bit every step.
  assign dir_left = (op_q == OP_SLL);
  assign fill     = is_sra & work_q[WIDTH-1];
  assign step_amt = (rem_q < STEP_R) ? rem_q[AW-1:0] : AW'(STEP);
  assign rem_next = rem_q - SW'(step_amt);

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .data     (work_q),
    .dir_left (dir_left),
    .fill     (fill),
    .amt      (step_amt),
    .result   (step_res)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    work_d      = work_q;
    out_d       = out_q;
    rem_d       = rem_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        if (accept) begin
          op_d       = op_e'(op);
          work_d     = a;
          rem_d      = shamt;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          if (shamt == '0) begin
            state_d     = DONE;
            out_d       = a;
            out_valid_d = 1'b1;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_d = step_res;
        rem_d  = rem_next;
        if (rem_next == '0) begin
          state_d     = DONE;
          out_d       = step_res;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= OP_SLL;
      work_q      <= '0;
      out_q       <= '0;
      rem_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      work_q      <= work_d;
      out_q       <= out_d;
      rem_q       <= rem_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out       = out_q;

endmodule
